// File: rtl/adat_rx_frame_parser.sv
// rtl/adat_rx_frame_parser.sv - ADAT receive frame parser: sync search, user bits, channel deserialisation, frame timing
//
// Purpose:
//   Takes the NRZI-decoded ADAT bit stream and recovers frame structure.
//   A frame is a run of at least SYNC_ZEROS zeros, a '1' marker, then 49
//   five-bit groups (4 data bits followed by a '1' separator). Group 0 holds
//   the user bits; groups 1..48 hold eight 24-bit channels, six nibbles each,
//   MSB nibble first. The clock-cycle distance between consecutive sync
//   detections is reported as the frame time.
//
// Ports:
//   i_clk         system clock
//   i_rst         asynchronous active-low reset
//   i_bit         decoded data bit, valid only with i_bit_valid
//   i_bit_valid   one-cycle strobe per received bit
//   o_frame_time  cycles between the last two sync detections
//   o_data        assembled 24-bit channel sample, first bit received is MSB
//   o_channel     channel index (0..7) belonging to o_data
//   o_data_valid  one-cycle pulse qualifying o_data/o_channel
//   o_sync        frame lock level, raised only after a fully good frame
//   o_user_bits   user bits of the last frame, first bit received is [3]
//   o_sync_err    one-cycle pulse on a bad separator bit

module adat_rx_frame_parser #(
    parameter int SYNC_ZEROS = 10,
    parameter int FT_WIDTH   = 12
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_bit,
    input  logic                i_bit_valid,
    output logic [FT_WIDTH-1:0] o_frame_time,
    output logic [23:0]         o_data,
    output logic [2:0]          o_channel,
    output logic                o_data_valid,
    output logic                o_sync,
    output logic [3:0]          o_user_bits,
    output logic                o_sync_err
);

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    localparam logic [3:0]          SYNC_ZEROS_L = 4'(SYNC_ZEROS);
    localparam logic [3:0]          ZRUN_MAX     = 4'hF;
    localparam logic [FT_WIDTH-1:0] FT_MAX       = '1;
    localparam logic [FT_WIDTH-1:0] FT_MAX_M1    = {{(FT_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [5:0]          LAST_GROUP   = 6'd48;
    localparam logic [2:0]          SEP_POS      = 3'd4;
    localparam logic [2:0]          LAST_NIBBLE  = 3'd5;

    state_t                state_q, state_d;
    logic [3:0]            zrun_q, zrun_d;
    logic [2:0]            pos_q, pos_d;
    logic [5:0]            group_q, group_d;
    logic [2:0]            nib_q, nib_d;
    logic [2:0]            chan_q, chan_d;
    logic [23:0]           shift_q, shift_d;
    logic [FT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                  seen_q, seen_d;

    logic [FT_WIDTH-1:0]   frame_time_q, frame_time_d;
    logic [23:0]           data_q, data_d;
    logic [2:0]            channel_q, channel_d;
    logic                  data_valid_q, data_valid_d;
    logic                  sync_q, sync_d;
    logic [3:0]            user_q, user_d;
    logic                  sync_err_q, sync_err_d;

    logic                  sync_det;
    logic                  timeout;
    logic [FT_WIDTH-1:0]   elapsed;

    // The counter is cleared on the sync edge itself, so at the next sync
    // edge it holds (elapsed - 1); add one back, holding at saturation.
    assign elapsed  = (cnt_q == FT_MAX) ? FT_MAX : cnt_q + 1'b1;
    assign sync_det = i_bit_valid && i_bit && (zrun_q >= SYNC_ZEROS_L);
    // Fires on the edge at which the counter enters saturation, once.
    assign timeout  = (cnt_q == FT_MAX_M1) && !sync_det;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= HUNT;
            zrun_q       <= '0;
            pos_q        <= '0;
            group_q      <= '0;
            nib_q        <= '0;
            chan_q       <= '0;
            shift_q      <= '0;
            cnt_q        <= '0;
            seen_q       <= 1'b0;
            frame_time_q <= '0;
            data_q       <= '0;
            channel_q    <= '0;
            data_valid_q <= 1'b0;
            sync_q       <= 1'b0;
            user_q       <= '0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            zrun_q       <= zrun_d;
            pos_q        <= pos_d;
            group_q      <= group_d;
            nib_q        <= nib_d;
            chan_q       <= chan_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            seen_q       <= seen_d;
            frame_time_q <= frame_time_d;
            data_q       <= data_d;
            channel_q    <= channel_d;
            data_valid_q <= data_valid_d;
            sync_q       <= sync_d;
            user_q       <= user_d;
            sync_err_q   <= sync_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        zrun_d       = zrun_q;
        pos_d        = pos_q;
        group_d      = group_q;
        nib_d        = nib_q;
        chan_d       = chan_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        seen_d       = seen_q;
        frame_time_d = frame_time_q;
        data_d       = data_q;
        channel_d    = channel_q;
        data_valid_d = 1'b0;
        sync_d       = sync_q;
        user_d       = user_q;
        sync_err_d   = 1'b0;

        // Zero-run tracking is independent of the FSM state.
        if (i_bit_valid) begin
            if (i_bit) begin
                zrun_d = '0;
            end else if (zrun_q != ZRUN_MAX) begin
                zrun_d = zrun_q + 1'b1;
            end
        end

        if (sync_det) begin
            cnt_d = '0;
        end else if (cnt_q != FT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (sync_det) begin
            // A sync detect restarts the frame from any state and beats a
            // coincident timeout.
            if (seen_q) begin
                frame_time_d = elapsed;
            end
            seen_d  = 1'b1;
            state_d = RECV;
            group_d = '0;
            pos_d   = '0;
            nib_d   = '0;
            chan_d  = '0;
            shift_d = '0;
        end else if (timeout) begin
            sync_d  = 1'b0;
            seen_d  = 1'b0;
            state_d = HUNT;
        end else if (state_q == RECV && i_bit_valid) begin
            if (pos_q != SEP_POS) begin
                // The 24-bit shifter naturally flushes the previous channel
                // after six nibbles, so no per-channel clear is needed.
                shift_d = {shift_q[22:0], i_bit};
                pos_d   = pos_q + 1'b1;
            end else if (i_bit) begin
                pos_d = '0;
                if (group_q == '0) begin
                    user_d = shift_q[3:0];
                end else if (nib_q == LAST_NIBBLE) begin
                    data_valid_d = 1'b1;
                    data_d       = shift_q;
                    channel_d    = chan_q;
                    chan_d       = chan_q + 1'b1;
                    nib_d        = '0;
                end else begin
                    nib_d = nib_q + 1'b1;
                end
                if (group_q == LAST_GROUP) begin
                    sync_d  = 1'b1;
                    state_d = HUNT;
                end else begin
                    group_d = group_q + 1'b1;
                end
            end else begin
                sync_err_d = 1'b1;
                sync_d     = 1'b0;
                state_d    = HUNT;
            end
        end
    end

    assign o_frame_time = frame_time_q;
    assign o_data       = data_q;
    assign o_channel    = channel_q;
    assign o_data_valid = data_valid_q;
    assign o_sync       = sync_q;
    assign o_user_bits  = user_q;
    assign o_sync_err   = sync_err_q;

endmodule

// File: doc/adat_rx_frame_parser.md
Name: adat_rx_frame_parser

Overview:
- Recovers ADAT frame structure from the decoded serial bit stream.
- Finds sync, extracts the 4 user bits, and deserialises eight 24-bit channels.
- Measures the frame period in clock cycles.
- Sits directly upstream of adat_rx_output_interface and drives its frame_time, data, channel, data_valid, sync and user_bits inputs.

Parameters:
- SYNC_ZEROS, 10: minimum run of consecutive 0 bits that qualifies as sync.
- FT_WIDTH, 12: width of the frame-time counter and output; saturates at 2^FT_WIDTH-1.

Ports:
- i_clk  in  1  system clock; only clock.
- i_rst  in  1  reset; asynchronous, active-low.
- i_bit  in  1  NRZI-decoded data bit; sampled only when i_bit_valid=1.
- i_bit_valid  in  1  one-cycle strobe per received bit.
- o_frame_time  out  FT_WIDTH  clock cycles between the last two sync detections.
- o_data  out  24  channel sample; first-received bit is the MSB.
- o_channel  out  3  channel index 0..7 of o_data.
- o_data_valid  out  1  one-cycle pulse; o_data/o_channel are valid in that cycle.
- o_sync  out  1  level; frame lock.
- o_user_bits  out  4  user bits of the last good frame; first-received bit is [3].
- o_sync_err  out  1  one-cycle pulse on a separator error.

Behaviour:
Reset:
- i_rst=0 asynchronously clears all outputs to 0, all counters and the frame-time-seen flag.
- FSM returns to HUNT.

Frame format, 256 bits:
- At least SYNC_ZEROS zeros, then a '1' marker.
- Then 49 groups of 5 bits each: 4 data bits followed by a '1' separator.
- Group 0 carries the user bits. Groups 1..48 are nibbles, channel 0 first, six nibbles per channel, MSB nibble first.

Zero-run counter:
- Counts consecutive i_bit=0 strobes, saturating at 15.
- Cleared on any i_bit=1 strobe.
- Runs in every state.

Sync detect:
- An i_bit=1 strobe with zero-run >= SYNC_ZEROS is a sync detect.
- On sync detect: FSM enters RECV with group=0 and bit=0, the shift register is cleared, and frame-time capture runs.
- A sync detect in any state restarts the frame.

FSM:
- HUNT: ignore data; wait for sync detect.
- RECV:
  - Bit positions 0..3 shift into the nibble register.
  - Position 4 is the separator check.
  - Separator=1: commit the group.
    - Group 0: latch o_user_bits.
    - Group g, with g a multiple of 6 and g>=6: pulse o_data_valid with o_channel=g/6-1 and o_data = the 24 assembled bits.
    - Group 48: set o_sync=1 and go to HUNT to await the next sync.
  - Separator=0: pulse o_sync_err, o_sync<=0, go to HUNT. No further channel pulses are emitted for that frame.

Latency:
- o_data_valid asserts the cycle after the i_bit_valid cycle that carries the final separator of the channel.
- o_user_bits updates with the same latency.
- At most one o_data_valid per strobe.

Frame time:
- A cycle counter is cleared on sync detect and increments every clock, saturating at 2^FT_WIDTH-1.
- On a sync detect with the seen flag set, o_frame_time <= elapsed cycles since the previous sync detect.
- The first sync detect after reset or timeout only sets the seen flag.

Timeout:
- When the counter reaches saturation: o_sync<=0, seen flag cleared, FSM to HUNT.
- o_frame_time holds its last value.
- If a sync detect coincides with saturation, the sync detect wins and o_frame_time <= saturated value.

Other rules:
- o_sync never rises mid-frame; it rises only at the end of a fully good frame.
- Channel pulses are emitted in every frame whose separators are good, regardless of o_sync.

Test Plan:
1. Bits every 8 cycles; two frames; user bits 0010; channel k data = 0xAA000k.
   -> Per frame, 8 pulses with channels 0..7 and the matching data.
   -> o_user_bits=0010.
   -> o_sync=1 after the first frame.
   -> o_frame_time=2048 after the second sync.
2. Channel 3 first-nibble separator forced to 0.
   -> o_sync_err single pulse, o_sync=0.
   -> No channel 3..7 pulses.
   -> The next good frame restores o_sync=1 and all 8 pulses.
3. Only 9 zeros before the marker.
   -> No frame starts, no pulses, o_sync stays 0.
4. Lock established, then i_bit_valid stopped.
   -> o_sync falls exactly 4095 cycles after the last sync detect.
   -> o_frame_time keeps 2048.
5. Async reset asserted mid-channel-4.
   -> All outputs 0 immediately, with no clock edge needed.
   -> After release, parsing resumes cleanly on the next sync.
